// File: rtl/buffets_pkg.sv
// Shared definitions for the buffet-side stream blocks:
// fill/drain state encoding and burst-length width helpers.
package buffets_pkg;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   // Bits needed to hold a word count of 0..depth
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Bits needed to address depth storage entries
   function automatic int idx_width(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/burst_lifo.sv
// Word stack for one burst: push at count, combinational read
// of the newest word at count-1, pop decrements count.
module burst_lifo
   import buffets_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int AW = idx_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;

   // Index the slot at count for writes, count-1 for reads
   always_comb begin
      wr_idx = AW'(count_q);
      rd_idx = '0;
      if (count_q != '0) begin
         rd_idx = AW'(count_q - CNT_W'(1));
      end
   end

   // Next count: push and pop never coincide
   always_comb begin
      count_d = count_q;
      if (push_i) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_i) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Occupancy register, cleared by reset
   always_ff @(posedge clk) begin
      if (!nreset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage array, deliberately left uncleared by reset
   always_ff @(posedge clk) begin
      if (push_i) begin
         mem_q[wr_idx] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_idx];
   assign count_o = count_q;

endmodule

// File: rtl/burst_reverse.sv
// Burst order reverser: fill a burst, then replay it last-word-first.
// Optional macro BURST_REVERSE_BITS_EN also bit-reverses each word.
module burst_reverse
   import buffets_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   input  logic             in_last_i,
   output logic             in_ready_o,
   output logic [WIDTH-1:0] out_data_o,
   output logic             out_valid_o,
   output logic             out_last_o,
   input  logic             out_ready_i,
   output logic [CNT_W-1:0] count_o,
   output logic             split_o
);

   state_e           state_q;
   logic             split_q;
   logic             push;
   logic             pop;
   logic             full_next;
   logic [WIDTH-1:0] rd_data;
   logic [CNT_W-1:0] count;

   burst_lifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_lifo (
      .clk     (clk),
      .nreset  (nreset),
      .push_i  (push),
      .data_i  (in_data_i),
      .pop_i   (pop),
      .data_o  (rd_data),
      .count_o (count)
   );

   assign push      = (state_q == FILL) && in_valid_i;
   assign pop       = (state_q == DRAIN) && out_ready_i;
   assign full_next = (count == CNT_W'(DEPTH - 1));

   // Fill/drain sequencing and the split pulse
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= FILL;
         split_q <= 1'b0;
      end else begin
         split_q <= 1'b0;
         case (state_q)
            FILL: begin
               if (push && (in_last_i || full_next)) begin
                  state_q <= DRAIN;
                  split_q <= !in_last_i;
               end
            end
            DRAIN: begin
               if (pop && (count == CNT_W'(1))) begin
                  state_q <= FILL;
               end
            end
            default: state_q <= FILL;
         endcase
      end
   end

   assign in_ready_o  = (state_q == FILL);
   assign out_valid_o = (state_q == DRAIN);
   assign out_last_o  = (state_q == DRAIN) && (count == CNT_W'(1));
   assign count_o     = count;
   assign split_o     = split_q;

`ifdef BURST_REVERSE_BITS_EN
   // Mirror each word end-for-end on the way out
   always_comb begin
      out_data_o = '0;
      for (int i = 0; i < WIDTH; i++) begin
         out_data_o[i] = rd_data[WIDTH-1-i];
      end
   end
`else
   assign out_data_o = rd_data;
`endif

endmodule
